// File: rtl/fuzz_stim_engine_if.sv
// Bus bundle between the fuzz stimulus engine and its harness.
// The harness side (master) supplies seed/run control and the DUT response;
// the engine side (slave) returns the stimulus vector and run status.
interface fuzz_stim_engine_if #(
    parameter int IN_W  = 258,
    parameter int OUT_W = 330,
    parameter int CNT_W = 16
);
    logic [31:0]      seed;
    logic             seed_load;
    logic             start;
    logic [CNT_W-1:0] num_cycles;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;
    logic [31:0]      signature;

    modport master (
        output seed, seed_load, start, num_cycles, dut_out,
        input  stim, stim_valid, busy, done, vec_count, signature
    );

    modport slave (
        input  seed, seed_load, start, num_cycles, dut_out,
        output stim, stim_valid, busy, done, vec_count, signature
    );
endinterface

// File: rtl/fuzz_stim_engine.sv
// Fuzz stimulus engine: packs successive 32-bit LCG outputs into an IN_W-bit
// DUT input vector, holds it for HOLD_CYC cycles, and folds the DUT response
// into a 32-bit MISR signature. Runs for a programmed number of vectors.
// Optional macro FUZZ_STIM_TRACE_EN enables simulation-only trace printing.
module fuzz_stim_engine #(
    parameter int          IN_W         = 258,
    parameter int          OUT_W        = 330,
    parameter int          CNT_W        = 16,
    parameter int          HOLD_CYC     = 1,
    parameter logic [31:0] SEED_DEFAULT = 32'hFD40B66F
) (
    input logic              clk,
    input logic              rst_n,
    fuzz_stim_engine_if.slave bus
);

    localparam int NWORDS = (IN_W + 31) / 32;
    localparam int NCHUNK = (OUT_W + 31) / 32;
    localparam int WI_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int HC_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(NWORDS - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             lcg;
    logic [NWORDS-1:0][31:0] shadow;
    logic [WI_W-1:0]         word_idx;
    logic [HC_W-1:0]         hold_cnt;
    logic [CNT_W-1:0]        target;

    logic [31:0]             lcg_step;
    logic [NWORDS-1:0][31:0] fill_vec;
    logic [NWORDS*32-1:0]    fill_flat;
    logic [NCHUNK*32-1:0]    padded;
    logic [31:0]             fold;
    logic [31:0]             sig_step;
    logic [CNT_W-1:0]        vec_inc;

    logic ctl_load, ctl_start, fill_last, hold_last, run_end;

    assign lcg_step = lcg * 32'h41C64E6D + 32'h3039;
    assign vec_inc  = bus.vec_count + CNT_W'(1);
    assign sig_step = {bus.signature[30:0],
                       bus.signature[31] ^ bus.signature[21] ^
                       bus.signature[1]  ^ bus.signature[0]} ^ fold;

    // Vector as it will look once the word generated this cycle is included.
    always_comb begin
        fill_vec           = shadow;
        fill_vec[word_idx] = lcg_step;
    end

    assign fill_flat = fill_vec;

    // XOR-fold the zero-padded DUT response into one 32-bit word.
    always_comb begin
        padded            = '0;
        padded[OUT_W-1:0] = bus.dut_out;
        fold              = '0;
        for (int i = 0; i < NCHUNK; i++) fold ^= padded[i*32 +: 32];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        ctl_load  = 1'b0;
        ctl_start = 1'b0;
        fill_last = 1'b0;
        hold_last = 1'b0;
        run_end   = 1'b0;
        case (state)
            IDLE, DONE: begin
                ctl_load = bus.seed_load;
                if (bus.start) begin
                    ctl_start = 1'b1;
                    state_nxt = (bus.num_cycles == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                fill_last = (word_idx == WI_LAST);
                if (fill_last) state_nxt = HOLD;
            end
            HOLD: begin
                hold_last = (hold_cnt == HC_LAST);
                if (hold_last) begin
                    run_end   = (vec_inc == target);
                    state_nxt = run_end ? DONE : FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: LCG, vector assembly, hold timing, signature and status.
    // Seed load precedes the run, so a same-cycle start uses the new seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcg            <= SEED_DEFAULT;
            shadow         <= '0;
            word_idx       <= '0;
            hold_cnt       <= '0;
            target         <= '0;
            bus.stim       <= '0;
            bus.stim_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.vec_count  <= '0;
            bus.signature  <= 32'hFFFFFFFF;
        end else begin
            bus.stim_valid <= fill_last;
            if (ctl_load) lcg <= bus.seed;
            if (ctl_start) begin
                target        <= bus.num_cycles;
                bus.vec_count <= '0;
                bus.signature <= 32'hFFFFFFFF;
                word_idx      <= '0;
                hold_cnt      <= '0;
                bus.busy      <= (bus.num_cycles != '0);
                bus.done      <= (bus.num_cycles == '0);
            end
            if (state == FILL) begin
                lcg              <= lcg_step;
                shadow[word_idx] <= lcg_step;
                if (fill_last) begin
                    bus.stim <= fill_flat[IN_W-1:0];
                    word_idx <= '0;
                    hold_cnt <= '0;
                end else begin
                    word_idx <= word_idx + WI_W'(1);
                end
            end
            if (state == HOLD) begin
                if (hold_last) begin
                    bus.signature <= sig_step;
                    bus.vec_count <= vec_inc;
                    if (run_end) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HC_W'(1);
                end
            end
        end
    end

`ifdef FUZZ_STIM_TRACE_EN
    // Simulation trace of each sampled vector and of run completion.
    always @(posedge clk) begin
        if (rst_n && hold_last) begin
            $write("CYCLE=%0d IN=%0h OUT=%0h\n", bus.vec_count, bus.stim, bus.dut_out);
            if (run_end) $display("TB_SIM_OK cycles=%0d", vec_inc);
        end
        if (rst_n && ctl_start && bus.num_cycles == '0)
            $display("TB_SIM_OK cycles=%0d", 0);
    end
`endif

endmodule

// File: tb/tb_fuzz_stim_engine.sv
// Testbench for fuzz_stim_engine: a 40-bit instance (two words, top word
// truncated to 8 bits) and a 258-bit instance with a 3-cycle hold, checked
// against an arithmetic LCG/MISR reference model.
module tb_fuzz_stim_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seed = '0;
    logic        seed_load = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_cycles = '0;
    logic [329:0] dut_out = '0;
    bit          sel = 1'b0;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    logic [31:0]  m_lcg [2];
    logic [287:0] m_stim[2];

    always #5 clk = ~clk;

    fuzz_stim_engine_if #(.IN_W(40),  .OUT_W(330), .CNT_W(16)) ia ();
    fuzz_stim_engine_if #(.IN_W(258), .OUT_W(330), .CNT_W(16)) ib ();

    assign ia.seed       = seed;
    assign ia.seed_load  = seed_load & ~sel;
    assign ia.start      = start & ~sel;
    assign ia.num_cycles = num_cycles;
    assign ia.dut_out    = dut_out;
    assign ib.seed       = seed;
    assign ib.seed_load  = seed_load & sel;
    assign ib.start      = start & sel;
    assign ib.num_cycles = num_cycles;
    assign ib.dut_out    = dut_out;

    fuzz_stim_engine #(.IN_W(40), .OUT_W(330), .CNT_W(16), .HOLD_CYC(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    fuzz_stim_engine #(.IN_W(258), .OUT_W(330), .CNT_W(16), .HOLD_CYC(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    logic [287:0] o_stim;
    logic         o_sv, o_busy, o_done;
    logic [15:0]  o_vc;
    logic [31:0]  o_sig;
    assign o_stim = sel ? 288'(ib.stim) : 288'(ia.stim);
    assign o_sv   = sel ? ib.stim_valid : ia.stim_valid;
    assign o_busy = sel ? ib.busy : ia.busy;
    assign o_done = sel ? ib.done : ia.done;
    assign o_vc   = sel ? ib.vec_count : ia.vec_count;
    assign o_sig  = sel ? ib.signature : ia.signature;

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h3039;
    endfunction

    function automatic logic [31:0] sig_upd(input logic [31:0] s, input logic [329:0] d);
        logic [351:0] p = 352'(d);
        logic [31:0]  f = '0;
        for (int i = 0; i < 11; i++) f ^= p[i*32 +: 32];
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
    endfunction

    function automatic logic [329:0] rnd330();
        logic [351:0] r;
        for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
        return r[329:0];
    endfunction

    // Next vector of the selected instance: consecutive LCG outputs, one per
    // word, with the bits above the input width discarded.
    task automatic mk_vec(output logic [287:0] v);
        int n = sel ? 9 : 2;
        int w = sel ? 258 : 40;
        v = '0;
        for (int k = 0; k < n; k++) begin
            m_lcg[sel] = lcg_next(m_lcg[sel]);
            v[k*32 +: 32] = m_lcg[sel];
        end
        for (int b = w; b < 288; b++) v[b] = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lcg[s]  = 32'hFD40B66F;
            m_stim[s] = '0;
        end
    endtask

    task automatic chk_reset_vals();
        bit keep = sel;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_stim", o_stim, 0);
            chk("rst_stim_valid", o_sv, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_vec_count", o_vc, 0);
            chk("rst_signature", o_sig, 32'hFFFFFFFF);
        end
        sel = keep;
        #1;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m_lcg[sel] = s;
    endtask

    // One run on the selected instance. dmode: 0 random dut_out, 1 zero, 2 one.
    // disturb pulses start/seed_load mid-run; rst_vec>0 resets during the
    // fill of that vector and abandons the run.
    task automatic run(input bit do_seed, input logic [31:0] s, input int n,
                       input int dmode, input bit disturb, input int rst_vec);
        int nw  = sel ? 9 : 2;
        int per = nw + (sel ? 3 : 1);
        int pulses = 0;
        logic [31:0]  esig = 32'hFFFFFFFF;
        logic [287:0] v;
        bit exp_sv;
        if (do_seed) m_lcg[sel] = s;
        seed = s;
        seed_load = do_seed;
        start = 1'b1;
        num_cycles = 16'(n);
        tick();
        seed_load = 1'b0;
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", o_done, 1);
            chk("zero_busy", o_busy, 0);
            chk("zero_vec_count", o_vc, 0);
            chk("zero_signature", o_sig, 32'hFFFFFFFF);
            chk("zero_stim", o_stim, m_stim[sel]);
            tick();
            chk("zero_done_hold", o_done, 1);
            chk("zero_stim_valid", o_sv, 0);
            return;
        end
        chk("start_busy", o_busy, 1);
        chk("start_done", o_done, 0);
        chk("start_vec_count", o_vc, 0);
        chk("start_signature", o_sig, 32'hFFFFFFFF);
        chk("start_stim", o_stim, m_stim[sel]);
        for (int c = 1; c <= n * per; c++) begin
            tick();
            start = 1'b0;
            seed_load = 1'b0;
            exp_sv = (pulses < n) && (c == nw + pulses * per);
            chk("stim_valid", o_sv, exp_sv);
            if (exp_sv) begin
                mk_vec(v);
                m_stim[sel] = v;
                pulses++;
                dut_out = (dmode == 0) ? rnd330() : (dmode == 1) ? 330'h0 : 330'h1;
                esig = sig_upd(esig, dut_out);
            end
            chk("stim", o_stim, m_stim[sel]);
            chk("done_timing", o_done, (c == n * per));
            if (disturb && c == nw + per + 1) begin
                seed = $urandom;
                seed_load = 1'b1;
                start = 1'b1;
                num_cycles = 16'd1;
            end
            if (rst_vec > 0 && c == (rst_vec - 1) * per + 1) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk_reset_vals();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
        end
        chk("end_vec_count", o_vc, n);
        chk("end_signature", o_sig, esig);
        chk("end_busy", o_busy, 0);
        tick();
        chk("done_hold", o_done, 1);
        chk("done_stim", o_stim, m_stim[sel]);
        chk("done_stim_valid", o_sv, 0);
    endtask

    initial begin
        logic [31:0] s, x;
        model_reset();
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Packing from seed 0 on the 40-bit instance.
        sel = 1'b0;
        load_seed(32'h0);
        run(1'b0, 32'h0, 1, 0, 1'b0, 0);
        chk("pack_const", o_stim, 40'h7E00003039);

        // Two vectors from seed 0: the truncated second output is not skipped.
        load_seed(32'h0);
        run(1'b0, 32'h0, 2, 0, 1'b0, 0);
        x = lcg_next(32'hD3DC167E);
        chk("trunc_word0", o_stim[31:0], x);
        chk("trunc_word1", o_stim[39:32], lcg_next(x) & 32'hFF);

        // Zero-length run leaves stim and lcg untouched.
        run(1'b0, 32'h0, 0, 0, 1'b0, 0);
        run(1'b0, 32'h0, 1, 0, 1'b0, 0);

        // Signature on the wide instance from the default seed.
        sel = 1'b1;
        run(1'b0, 32'h0, 1, 1, 1'b0, 0);
        chk("sig_zero", o_sig, 32'hFFFFFFFE);
        run(1'b0, 32'h0, 1, 2, 1'b0, 0);
        chk("sig_one", o_sig, 32'hFFFFFFFF);

        // Start/seed_load pulsed mid-run are ignored; lcg continues after.
        run(1'b1, $urandom, 5, 0, 1'b1, 0);
        run(1'b0, 32'h0, 2, 0, 1'b0, 0);

        // Seed load and start in the same cycle.
        sel = 1'b0;
        run(1'b1, $urandom, 4, 0, 1'b1, 0);

        // Reset during fill of vector 3, then replay from the same seed.
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            s = $urandom;
            run(1'b1, s, 5, 0, 1'b0, 3);
            run(1'b1, s, 3, 0, 1'b0, 0);
        end

        // Randomised runs on both instances.
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            run($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 4), 0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fuzz_stim_engine.md
Name: fuzz_stim_engine

Overview:
- Synthesizable, parametrised stimulus engine for the fuzz harness.
- Drives an arbitrary-width DUT input bus from the team's 32-bit LCG, with the same word packing the testbench generators use.
- Holds each vector for a configurable number of cycles, runs for a programmed vector count, and compacts the DUT output into a 32-bit MISR signature for cross-simulator comparison.
- Instantiated alongside the DUT inside a harness top, in place of behavioural initial-block stimulus.

Parameters:
- IN_W, 258, DUT input width; NWORDS = ceil(IN_W/32).
- OUT_W, 330, DUT output width folded into the signature.
- CNT_W, 16, width of the vector counter and num_cycles.
- HOLD_CYC, 1, cycles each vector is held before its output is sampled; must be >= 1.
- SEED_DEFAULT, 32'hFD40B66F, LCG state after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- seed  in  32  seed value.
- seed_load  in  1  load seed into the LCG; honoured only when not busy.
- start  in  1  begin a run; honoured only when not busy.
- num_cycles  in  CNT_W  vectors per run, sampled at start.
- dut_out  in  OUT_W  DUT output, sampled at the end of each hold window.
- stim  out  IN_W  DUT input vector.
- stim_valid  out  1  one-cycle pulse on the first cycle a new vector is on stim.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- vec_count  out  CNT_W  vectors sampled in this run.
- signature  out  32  MISR value.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: stim=0, stim_valid=0, busy=0, done=0, vec_count=0, signature=32'hFFFFFFFF, lcg=SEED_DEFAULT, state=IDLE.
- LCG step: lcg_next = lcg*32'h41C64E6D + 32'h3039, mod 2^32. Each step's result is one output word.
- Vector packing:
  - Word k of a vector is the (k+1)th LCG output since the vector started.
  - Word k goes to stim[32k+31:32k].
  - The top word is truncated to its low IN_W-32*(NWORDS-1) bits.
  - The LCG advances exactly NWORDS times per vector, truncation included. No steps are skipped between vectors.
- State IDLE/DONE:
  - seed_load=1 sets lcg=seed.
  - start=1 captures num_cycles, clears vec_count, sets signature=32'hFFFFFFFF, clears done, and sets busy.
  - It then moves to FILL, or to DONE on the next cycle if num_cycles=0.
  - seed_load and start in the same cycle: the seed is loaded first and the run uses the new seed.
- State FILL:
  - One LCG step per cycle, NWORDS cycles, accumulating into a shadow register. stim stays unchanged during FILL.
  - On the final FILL edge, the shadow is copied to stim. stim_valid=1 on the next cycle only.
  - Go to HOLD.
- State HOLD:
  - HOLD_CYC cycles.
  - On the last HOLD edge: signature = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ F, where F = XOR of all 32-bit chunks of dut_out, zero-padded at the top. vec_count is incremented on the same edge.
  - If the new vec_count == captured num_cycles, go to DONE; otherwise go to FILL.
- Vector period is NWORDS+HOLD_CYC cycles. stim is stable for that whole period, apart from the update edge.
- DONE: busy=0, done=1. stim, vec_count, signature and lcg are held.
- start or seed_load while busy: ignored, no side effect.
- rst_n asserted mid-run: all state returns to reset values immediately. The partial vector is discarded.
- vec_count never wraps within a run; the maximum run is 2^CNT_W-1 vectors.

Optional Feature:
- Macro FUZZ_STIM_TRACE_EN.
- Defined:
  - Simulation-only $write of "CYCLE=%0d IN=%0h OUT=%0h\n" on each signature-update edge, using vec_count, stim and dut_out.
  - $display "TB_SIM_OK cycles=%0d" on entry to DONE.
- Undefined: no simulation output; RTL behaviour is identical.

Test Plan:
- Seed and packing: IN_W=40, seed_load with seed=0, then start with num_cycles=1 -> stim=40'h7E00003039 with a single stim_valid pulse 2 cycles after FILL entry; done=1 and vec_count=1 after HOLD.
- Truncation continuity: IN_W=40, seed=0, two vectors -> the second vector is built from LCG outputs 3 and 4 (output 2, 32'hD3DC167E, was truncated to 8'h7E, not skipped). Check against a bench LCG model.
- Zero-length run: num_cycles=0 -> done=1 the cycle after start, vec_count=0, signature=32'hFFFFFFFF, stim unchanged.
- Signature: default widths, dut_out tied to 0, one vector -> signature=32'hFFFFFFFE. With dut_out=330'h1 -> 32'hFFFFFFFF.
- Busy protection: start and seed_load pulsed mid-run with num_cycles=5 -> the run completes 5 vectors and lcg continues from the original seed.
- Async reset: rst_n dropped during FILL of vector 3 -> all outputs are at reset values within the same cycle. A following start with the same seed reproduces the first-run stim sequence exactly.
